// File: rtl/mips_mem_responder.sv
// Word-addressed memory responder serving MIPS fetch (if_*) and data (dm_*) ports over req/ack.
// Optional build macro MEM_ROUND_ROBIN_EN switches arbitration from fixed data priority to round-robin.
`timescale 1ns/1ps
module mips_mem_responder #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk1,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_ack,
  output logic [31:0] dm_rdata,
  output logic        err,
  output logic        busy
);

  localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  if (WAIT_CYCLES > 15) begin : g_bad_wait
    $error("WAIT_CYCLES must be in 0..15");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  typedef enum logic [1:0] {G_NONE, G_IF, G_DM} gnt_t;

  state_t      state_q, state_d;
  gnt_t        gnt_q, gnt_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic        if_ack_q, dm_ack_q, err_q;
  logic [31:0] if_rdata_q, dm_rdata_q;
  logic        pick_dm;
  logic        access;
  logic        oor;
  logic        wr_en;
  logic [AW-1:0] idx;

  logic [31:0] mem_q [DEPTH];

`ifdef MEM_ROUND_ROBIN_EN
  logic last_dm_q, last_dm_d;
`endif

  // Arbitration: a lone request always wins; ties go to data unless round-robin says otherwise.
  always_comb begin
`ifdef MEM_ROUND_ROBIN_EN
    pick_dm = dm_req && (!if_req || !last_dm_q);
`else
    pick_dm = dm_req;
`endif
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    access  = 1'b0;
`ifdef MEM_ROUND_ROBIN_EN
    last_dm_d = last_dm_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (if_req || dm_req) begin
          gnt_d   = pick_dm ? G_DM : G_IF;
          addr_d  = pick_dm ? dm_addr : if_addr;
          we_d    = pick_dm && dm_we;
          wdata_d = dm_wdata;
`ifdef MEM_ROUND_ROBIN_EN
          last_dm_d = pick_dm;
`endif
          if (WAIT_CYCLES > 0) begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end else begin
            state_d = S_RESP;
            access  = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
          access  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        gnt_d   = G_NONE;
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = G_NONE;
      end
    endcase
  end

  // The access uses the *_d view so a zero-wait accept reads/writes on the same edge it latches.
  assign oor   = (addr_d >= DEPTH_W);
  assign idx   = addr_d[AW-1:0];
  assign wr_en = rst_n && access && we_d && !oor;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      gnt_q      <= G_NONE;
      cnt_q      <= 4'd0;
      addr_q     <= 32'd0;
      we_q       <= 1'b0;
      wdata_q    <= 32'd0;
      if_ack_q   <= 1'b0;
      dm_ack_q   <= 1'b0;
      err_q      <= 1'b0;
      if_rdata_q <= 32'd0;
      dm_rdata_q <= 32'd0;
`ifdef MEM_ROUND_ROBIN_EN
      last_dm_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      if_ack_q <= access && (gnt_d == G_IF);
      dm_ack_q <= access && (gnt_d == G_DM);
      err_q    <= access && oor;
`ifdef MEM_ROUND_ROBIN_EN
      last_dm_q <= last_dm_d;
`endif
      if (access && !we_d) begin
        if (gnt_d == G_IF) begin
          if_rdata_q <= oor ? 32'd0 : mem_q[idx];
        end else begin
          dm_rdata_q <= oor ? 32'd0 : mem_q[idx];
        end
      end
    end
  end

  // Array storage has no reset; contents survive rst_n.
  always_ff @(posedge clk1) begin
    if (wr_en) begin
      mem_q[idx] <= wdata_d;
    end
  end

  assign if_ack   = if_ack_q;
  assign dm_ack   = dm_ack_q;
  assign err      = err_q;
  assign if_rdata = if_rdata_q;
  assign dm_rdata = dm_rdata_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_mips_mem_responder.sv
// Bench for mips_mem_responder: three instances (WAIT_CYCLES 1, 0, 3) checked against a word-array model.
`timescale 1ns/1ps
module tb_mips_mem_responder;

  localparam int ND    = 3;
  localparam int DEPTH = 1024;

  logic        clk1 = 1'b0;
  logic        rst_n;
  logic        if_req   [ND];
  logic [31:0] if_addr  [ND];
  logic        if_ack   [ND];
  logic [31:0] if_rdata [ND];
  logic        dm_req   [ND];
  logic        dm_we    [ND];
  logic [31:0] dm_addr  [ND];
  logic [31:0] dm_wdata [ND];
  logic        dm_ack   [ND];
  logic [31:0] dm_rdata [ND];
  logic        err      [ND];
  logic        busy     [ND];

  logic [31:0] mdl_mem   [ND][DEPTH];
  bit          known     [ND][DEPTH];
  logic [31:0] exp_if_rd [ND];
  logic [31:0] exp_dm_rd [ND];
  int checks;
  int errors;

  always #5 clk1 = ~clk1;

  mips_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(1)) u_w1 (
    .clk1(clk1), .rst_n(rst_n),
    .if_req(if_req[0]), .if_addr(if_addr[0]), .if_ack(if_ack[0]), .if_rdata(if_rdata[0]),
    .dm_req(dm_req[0]), .dm_we(dm_we[0]), .dm_addr(dm_addr[0]), .dm_wdata(dm_wdata[0]),
    .dm_ack(dm_ack[0]), .dm_rdata(dm_rdata[0]), .err(err[0]), .busy(busy[0]));

  mips_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) u_w0 (
    .clk1(clk1), .rst_n(rst_n),
    .if_req(if_req[1]), .if_addr(if_addr[1]), .if_ack(if_ack[1]), .if_rdata(if_rdata[1]),
    .dm_req(dm_req[1]), .dm_we(dm_we[1]), .dm_addr(dm_addr[1]), .dm_wdata(dm_wdata[1]),
    .dm_ack(dm_ack[1]), .dm_rdata(dm_rdata[1]), .err(err[1]), .busy(busy[1]));

  mips_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(3)) u_w3 (
    .clk1(clk1), .rst_n(rst_n),
    .if_req(if_req[2]), .if_addr(if_addr[2]), .if_ack(if_ack[2]), .if_rdata(if_rdata[2]),
    .dm_req(dm_req[2]), .dm_we(dm_we[2]), .dm_addr(dm_addr[2]), .dm_wdata(dm_wdata[2]),
    .dm_ack(dm_ack[2]), .dm_rdata(dm_rdata[2]), .err(err[2]), .busy(busy[2]));

  function automatic int wc(input int d);
    case (d)
      0: return 1;
      1: return 0;
      default: return 3;
    endcase
  endfunction

  // One complete transaction on instance d; expects the ack 1+WAIT cycles after the accepting edge.
  task automatic do_xfer(input int d, input bit is_dm, input bit we,
                         input logic [31:0] addr, input logic [31:0] wdata);
    int lat;
    bit seen;
    bit oor;
    logic ack_me, ack_other;
    logic [31:0] rd;
    lat  = 1 + wc(d);
    oor  = (addr >= 32'(DEPTH));
    seen = 1'b0;
    if (is_dm) begin
      dm_req[d] = 1'b1; dm_we[d] = we; dm_addr[d] = addr; dm_wdata[d] = wdata;
    end else begin
      if_req[d] = 1'b1; if_addr[d] = addr;
    end
    @(posedge clk1);
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(negedge clk1);
      ack_me    = is_dm ? dm_ack[d] : if_ack[d];
      ack_other = is_dm ? if_ack[d] : dm_ack[d];
      checks++;
      if (busy[d] !== 1'b1 || ack_other !== 1'b0) begin
        errors++;
        $display("FAIL busy_other d%0d cycle %0d: busy=%b other_ack=%b, want 1/0", d, k, busy[d], ack_other);
      end
      if (ack_me === 1'b1) begin
        seen = 1'b1;
        if (we && !oor) begin
          mdl_mem[d][addr[9:0]] = wdata;
          known[d][addr[9:0]]   = 1'b1;
        end
        if (!we) begin
          rd = oor ? 32'd0 : mdl_mem[d][addr[9:0]];
          if (is_dm) exp_dm_rd[d] = rd;
          else       exp_if_rd[d] = rd;
        end
        checks++;
        if (k != lat) begin
          errors++;
          $display("FAIL latency d%0d addr %h: ack cycle %0d, want %0d", d, addr, k, lat);
        end
        checks++;
        if (err[d] !== oor) begin
          errors++;
          $display("FAIL err d%0d addr %h: got %b want %b", d, addr, err[d], oor);
        end
        checks++;
        if (if_rdata[d] !== exp_if_rd[d]) begin
          errors++;
          $display("FAIL if_rdata d%0d addr %h: got %h want %h", d, addr, if_rdata[d], exp_if_rd[d]);
        end
        checks++;
        if (dm_rdata[d] !== exp_dm_rd[d]) begin
          errors++;
          $display("FAIL dm_rdata d%0d addr %h: got %h want %h", d, addr, dm_rdata[d], exp_dm_rd[d]);
        end
        if (is_dm) dm_req[d] = 1'b0;
        else       if_req[d] = 1'b0;
      end else begin
        checks++;
        if (err[d] !== 1'b0) begin
          errors++;
          $display("FAIL err_early d%0d cycle %0d: got %b want 0", d, k, err[d]);
        end
        if_addr[d]  = $urandom;
        dm_addr[d]  = $urandom;
        dm_wdata[d] = $urandom;
        dm_we[d]    = 1'($urandom);
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout d%0d addr %h: no ack within 20 cycles, want cycle %0d", d, addr, lat);
      if_req[d] = 1'b0;
      dm_req[d] = 1'b0;
    end
    @(negedge clk1);
    checks++;
    if (if_ack[d] !== 1'b0 || dm_ack[d] !== 1'b0 || busy[d] !== 1'b0) begin
      errors++;
      $display("FAIL after_ack d%0d: if_ack=%b dm_ack=%b busy=%b, want 0/0/0", d, if_ack[d], dm_ack[d], busy[d]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk1);
    for (int d = 0; d < ND; d++) begin
      exp_if_rd[d] = 32'd0;
      exp_dm_rd[d] = 32'd0;
      checks++;
      if (if_ack[d] !== 1'b0 || dm_ack[d] !== 1'b0 || err[d] !== 1'b0 || busy[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_ctrl d%0d: if_ack=%b dm_ack=%b err=%b busy=%b, want all 0",
                 d, if_ack[d], dm_ack[d], err[d], busy[d]);
      end
      checks++;
      if (if_rdata[d] !== 32'd0 || dm_rdata[d] !== 32'd0) begin
        errors++;
        $display("FAIL reset_rdata d%0d: if_rdata=%h dm_rdata=%h, want 0/0", d, if_rdata[d], dm_rdata[d]);
      end
    end
    rst_n = 1'b1;
    @(negedge clk1);
  endtask

  task automatic test_basic_fetch();
    do_xfer(0, 1'b1, 1'b1, 32'd5, 32'h2801_0004);
    do_xfer(0, 1'b0, 1'b0, 32'd5, 32'd0);
    checks++;
    if (if_rdata[0] !== 32'h2801_0004) begin
      errors++;
      $display("FAIL basic_fetch: if_rdata=%h want 28010004", if_rdata[0]);
    end
  endtask

  task automatic test_store_load();
    do_xfer(0, 1'b1, 1'b1, 32'd20, 32'hDEAD_BEEF);
    do_xfer(0, 1'b1, 1'b0, 32'd20, 32'd0);
    checks++;
    if (dm_rdata[0] !== 32'hDEAD_BEEF || if_rdata[0] !== 32'h2801_0004) begin
      errors++;
      $display("FAIL store_load: dm_rdata=%h if_rdata=%h, want deadbeef/28010004", dm_rdata[0], if_rdata[0]);
    end
  endtask

  task automatic test_contention();
    int if_cyc, dm_cyc, if_n, dm_n, first, second, exp_if_cyc, exp_dm_cyc;
    logic [31:0] wa, wb;
    wa = $urandom;
    wb = $urandom;
    do_xfer(0, 1'b1, 1'b1, 32'd0, wa);
    do_xfer(0, 1'b1, 1'b1, 32'd1, wb);
    first  = 1 + wc(0);
    second = first + 2 + wc(0);
`ifdef MEM_ROUND_ROBIN_EN
    exp_if_cyc = first;  exp_dm_cyc = second;
`else
    exp_dm_cyc = first;  exp_if_cyc = second;
`endif
    if_req[0] = 1'b1; if_addr[0] = 32'd0;
    dm_req[0] = 1'b1; dm_we[0] = 1'b0; dm_addr[0] = 32'd1;
    if_cyc = 0; dm_cyc = 0; if_n = 0; dm_n = 0;
    @(posedge clk1);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk1);
      if (if_ack[0] === 1'b1) begin
        if_n++;
        if (if_cyc == 0) if_cyc = k;
        if_req[0] = 1'b0;
      end
      if (dm_ack[0] === 1'b1) begin
        dm_n++;
        if (dm_cyc == 0) dm_cyc = k;
        dm_req[0] = 1'b0;
      end
    end
    exp_if_rd[0] = wa;
    exp_dm_rd[0] = wb;
    checks++;
    if (if_cyc != exp_if_cyc || if_n != 1) begin
      errors++;
      $display("FAIL contention_if: ack cycle %0d count %0d, want cycle %0d count 1", if_cyc, if_n, exp_if_cyc);
    end
    checks++;
    if (dm_cyc != exp_dm_cyc || dm_n != 1) begin
      errors++;
      $display("FAIL contention_dm: ack cycle %0d count %0d, want cycle %0d count 1", dm_cyc, dm_n, exp_dm_cyc);
    end
    checks++;
    if (if_rdata[0] !== wa || dm_rdata[0] !== wb) begin
      errors++;
      $display("FAIL contention_data: if_rdata=%h dm_rdata=%h, want %h/%h", if_rdata[0], dm_rdata[0], wa, wb);
    end
  endtask

  task automatic test_out_of_range();
    do_xfer(0, 1'b1, 1'b1, 32'd1024, 32'h1234_5678);
    do_xfer(0, 1'b1, 1'b0, 32'd0, 32'd0);
    do_xfer(0, 1'b1, 1'b0, 32'd1024, 32'd0);
    do_xfer(0, 1'b0, 1'b0, 32'h0000_0405, 32'd0);
    do_xfer(0, 1'b1, 1'b1, 32'h8000_0005, 32'hBAD0_BAD0);
    do_xfer(0, 1'b0, 1'b0, 32'd5, 32'd0);
    checks++;
    if (if_rdata[0] !== 32'h2801_0004) begin
      errors++;
      $display("FAIL oor_no_wrap: if_rdata=%h want 28010004", if_rdata[0]);
    end
  endtask

  task automatic test_reset_midop();
    do_xfer(2, 1'b1, 1'b1, 32'd7, 32'h0000_0001);
    dm_req[2] = 1'b1; dm_we[2] = 1'b1; dm_addr[2] = 32'd7; dm_wdata[2] = 32'h0000_00FF;
    @(posedge clk1);
    @(negedge clk1);
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy[2] !== 1'b0 || dm_ack[2] !== 1'b0) begin
      errors++;
      $display("FAIL midop_abort: busy=%b dm_ack=%b, want 0/0", busy[2], dm_ack[2]);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk1);
      checks++;
      if (dm_ack[2] !== 1'b0 || busy[2] !== 1'b0) begin
        errors++;
        $display("FAIL midop_in_reset cycle %0d: dm_ack=%b busy=%b, want 0/0", k, dm_ack[2], busy[2]);
      end
    end
    dm_req[2] = 1'b0;
    rst_n = 1'b1;
    for (int d = 0; d < ND; d++) begin
      exp_if_rd[d] = 32'd0;
      exp_dm_rd[d] = 32'd0;
    end
    @(negedge clk1);
    do_xfer(2, 1'b1, 1'b0, 32'd7, 32'd0);
    checks++;
    if (dm_rdata[2] !== 32'h0000_0001) begin
      errors++;
      $display("FAIL midop_no_write: dm_rdata=%h want 00000001", dm_rdata[2]);
    end
  endtask

  task automatic test_back_to_back();
    int nack;
    logic exp_ack;
    do_xfer(1, 1'b1, 1'b1, 32'd3, $urandom);
    do_xfer(1, 1'b1, 1'b1, 32'd4, $urandom);
    nack = 0;
    if_req[1] = 1'b1; if_addr[1] = 32'd3;
    @(posedge clk1);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk1);
      exp_ack = (k == 1 || k == 3);
      checks++;
      if (if_ack[1] !== exp_ack) begin
        errors++;
        $display("FAIL b2b_ack cycle %0d: got %b want %b", k, if_ack[1], exp_ack);
      end
      if (if_ack[1] === 1'b1) begin
        nack++;
        exp_if_rd[1] = mdl_mem[1][(nack == 1) ? 3 : 4];
        checks++;
        if (if_rdata[1] !== exp_if_rd[1]) begin
          errors++;
          $display("FAIL b2b_data ack %0d: got %h want %h", nack, if_rdata[1], exp_if_rd[1]);
        end
        if (nack == 1) if_addr[1] = 32'd4;
        else           if_req[1]  = 1'b0;
      end
    end
    if_req[1] = 1'b0;
  endtask

  task automatic test_random();
    for (int d = 0; d < ND; d++) begin
      for (int n = 0; n < 30; n++) begin
        bit is_dm;
        bit we;
        int sel;
        logic [31:0] addr;
        is_dm = 1'($urandom_range(0, 1));
        we    = is_dm && ($urandom_range(0, 1) == 1);
        sel   = $urandom_range(0, 7);
        if (sel == 0)      addr = 32'(DEPTH) + 32'($urandom_range(0, 4000));
        else if (sel == 1) addr = $urandom | 32'h0000_0400;
        else               addr = 32'($urandom_range(0, 31));
        if (!we && addr < 32'(DEPTH) && !known[d][addr[9:0]]) begin
          is_dm = 1'b1;
          we    = 1'b1;
        end
        do_xfer(d, is_dm, we, addr, $urandom);
        repeat ($urandom_range(0, 2)) @(negedge clk1);
      end
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    for (int d = 0; d < ND; d++) begin
      if_req[d] = 1'b0; if_addr[d] = 32'd0;
      dm_req[d] = 1'b0; dm_we[d] = 1'b0; dm_addr[d] = 32'd0; dm_wdata[d] = 32'd0;
      exp_if_rd[d] = 32'd0;
      exp_dm_rd[d] = 32'd0;
      for (int a = 0; a < DEPTH; a++) begin
        known[d][a]   = 1'b0;
        mdl_mem[d][a] = 32'd0;
      end
    end
    rst_n = 1'b0;
    test_reset();
    test_basic_fetch();
    test_store_load();
    test_contention();
    test_out_of_range();
    test_reset_midop();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_mem_responder.md
Name: mips_mem_responder

Overview:
- Memory-side responder for the MIPS-32 pipeline. It serves instruction-fetch reads and data load/store requests from the datapath over a req/ack handshake.
- Single-ported word-addressed array; the two request ports are arbitrated, and a programmable wait-state count models slower memory.
- Sits between the pipeline's IF/MEM stages and the shared 1024-word memory.

Parameters:
- DEPTH, 1024, number of 32-bit words in the array
- WAIT_CYCLES, 1, extra wait states between accepting a request and acking it (0..15)

Ports:
- clk1  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; held high with if_addr stable until if_ack
- if_addr  in  32  fetch word address
- if_ack  out  1  one-cycle pulse; fetch complete, if_rdata valid this cycle
- if_rdata  out  32  fetched instruction word
- dm_req  in  1  data request; held high with dm_we/dm_addr/dm_wdata stable until dm_ack
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  32  data word address
- dm_wdata  in  32  store data
- dm_ack  out  1  one-cycle pulse; data access complete, dm_rdata valid for loads
- dm_rdata  out  32  load data
- err  out  1  pulses with the ack when the serviced address is out of range
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, wait counter=0, grant=none.
  - if_ack=0, dm_ack=0, err=0, busy=0, if_rdata=0, dm_rdata=0.
  - Array contents are NOT cleared.
- States: IDLE, WAIT, RESP.
- IDLE:
  - If any req is high on edge N, latch the granted port's addr/we/wdata and the grant.
  - Go to WAIT if WAIT_CYCLES>0 (counter loaded with WAIT_CYCLES-1), otherwise go to RESP.
  - Arbitration: dm_req has fixed priority over if_req. This lets the pipeline drain and prevents deadlock.
- WAIT: decrement the counter; go to RESP when the counter is 0 at the edge.
- Array access happens on the edge entering RESP:
  - Read: array word to the granted port's rdata register.
  - Write: dm_wdata committed to the array.
- RESP:
  - The granted port's ack=1 for exactly one cycle; rdata is valid in that cycle and holds its value afterwards until the next access on that port.
  - All reqs are ignored; next state is IDLE unconditionally.
- Latency: request seen at edge N, ack high in cycle N+1+WAIT_CYCLES. Max throughput is one transfer per WAIT_CYCLES+2 cycles.
- Latched values are used after accept; changes on the input buses during WAIT/RESP have no effect.
- Store ack: dm_rdata is unchanged.
- Out of range (latched addr >= DEPTH):
  - No array write.
  - Read returns 32'h00000000.
  - err=1 together with the ack; the timing is otherwise identical.
- Simultaneous if_req and dm_req in IDLE: data is served first. Fetch is accepted in the IDLE cycle following the data RESP, provided if_req is still high.
- A requester that drops req before ack is a protocol violation. The responder still completes the latched transaction and pulses ack.
- Reset mid-operation: the transaction is aborted and no ack is issued. A store is not written if reset asserts before the edge entering RESP.
- Address bits above log2(DEPTH) are used only for the range check; no wrap-around.

Optional Feature:
- Macro: MEM_ROUND_ROBIN_EN
- Defined:
  - Arbitration is round-robin. When both reqs are high in IDLE, the port NOT granted last wins.
  - The last-grant flag resets to "fetch", so data wins the first tie.
  - A lone request is always granted.
- Undefined: fixed data-over-fetch priority as above; the last-grant flag is absent.

Test Plan:
- Basic fetch, WAIT_CYCLES=1:
  - Preload word 5 = 32'h28010004.
  - Pulse-hold if_req with if_addr=5 at edge 0 -> if_ack=1 in cycle 2, if_rdata=32'h28010004, err=0, busy high in cycles 1-2.
- Store then load:
  - dm_req, dm_we=1, dm_addr=20, dm_wdata=32'hDEADBEEF -> dm_ack in cycle 2.
  - Then load from addr 20 -> dm_rdata=32'hDEADBEEF; if_rdata unchanged.
- Contention:
  - if_req (addr 0) and dm_req load (addr 1) both high at edge 0 -> dm_ack cycle 2, if_ack cycle 5.
  - With MEM_ROUND_ROBIN_EN and a prior data grant -> if_ack cycle 2, dm_ack cycle 5.
- Out of range:
  - Store to addr 1024 with data 32'h12345678 -> dm_ack and err high in the same cycle.
  - A subsequent load from addr 0 is unchanged; a load from addr 1024 returns 0 with err=1.
- Reset mid-op:
  - WAIT_CYCLES=3, store to addr 7 (old value 32'h1, new 32'hFF); assert rst_n=0 during WAIT -> no dm_ack, busy=0 immediately.
  - After release, a load from addr 7 returns 32'h1.
- WAIT_CYCLES=0 back-to-back:
  - if_req held high for two fetches, addrs 3 then 4 -> acks in cycles 1 and 3, correct data each time, no double ack.
